tetris_pixel_mixer: RTL and testbench
=====================================

Name: tetris_pixel_mixer

Overview:
- Parametrised per-pixel colour compositor for the VGA Tetris display path; successor to the 1-bit-per-channel game display stage.
- Merges N prioritised multi-bit colour layers (border, fixed, moving, next, hold, score text, digits, ...) into one RGB pixel.
- Adds a game-over overlay with frame-counted blink, then steady display.
- Sits between the layer generators and the VGA output pins; all inputs are aligned to the same pixel coordinate.

Parameters:
- COLOR_W, 4, bits per colour channel.
- NUM_LAYERS, 8, number of colour layers; index NUM_LAYERS-1 has highest priority.
- BLINK_FRAMES, 30, frames per blink half-period.
- BLINK_TOGGLES, 6, overlay toggles before steady state; even value, >=2.
- BG_RGB, 0, packed 3*COLOR_W background colour (R in MSBs).

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- sync_ready_sig  input  1  active-video region; low means blank
- frame_start  input  1  one-cycle pulse at start of each frame
- ingame_sig  input  1  1 = game running, 0 = game over
- layer_en  input  NUM_LAYERS  per-layer pixel hit
- layer_rgb  input  NUM_LAYERS*3*COLOR_W  per-layer colour; layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W], R in MSBs
- pic_over_data  input  1  "GAME OVER" bitmap pixel
- red_out  output  COLOR_W  red
- green_out  output  COLOR_W  green
- blue_out  output  COLOR_W  blue
- over_state  output  2  current FSM state, for debug/LED

Behaviour:
- Reset: all pipeline registers, red_out/green_out/blue_out = 0, over_state = PLAY (2'd0), blink counter = 0, toggle counter = 0, overlay_vis = 1.
- Pipeline latency is 2 clocks from inputs to RGB outputs, fully pipelined with one pixel per clock.
- Stage 1 (registered):
  - sel_rgb = colour of the highest-index layer with layer_en set; BG_RGB if none set.
  - Also registers hit = |layer_en, pic_over_data and sync_ready_sig.
- Stage 2 (registered):
  - If stage-1 active = 0, output 0 on all channels.
  - Otherwise, if overlay applies (state != PLAY, overlay_vis = 1, over pixel = 1), output R = all ones, G = 0, B = 0.
  - Otherwise output sel_rgb.
- FSM states: PLAY = 0, OVER_FLASH = 1, OVER_STEADY = 2; 3 is unused and recovers to PLAY on the next clock.
  - PLAY -> OVER_FLASH when ingame_sig = 0; clear counters; overlay_vis = 1.
  - OVER_FLASH, on each frame_start: increment blink counter.
    - When the counter reaches BLINK_FRAMES-1: reset it to 0, invert overlay_vis, increment the toggle counter.
    - When the toggle counter reaches BLINK_TOGGLES: go to OVER_STEADY with overlay_vis = 1.
  - OVER_STEADY: hold; overlay is always visible.
  - Any non-PLAY state -> PLAY when ingame_sig = 1. This has priority over a simultaneous frame_start; counters are cleared.
- frame_start is ignored in PLAY and OVER_STEADY.
- The state and overlay_vis used by stage 2 are the registered values at that clock; no extra alignment is applied (frame-boundary skew is at most 1 pixel).
- Counter widths are $clog2(BLINK_FRAMES) and $clog2(BLINK_TOGGLES+1); they never wrap because they are compared before increment.
- Reset asserted mid-frame clears everything immediately; outputs are 0 until 2 clocks after reset release with valid inputs.

Optional Feature:
- Macro: TETRIS_PIXEL_MIXER_DIM_BG_EN.
- Defined: in OVER_FLASH and OVER_STEADY, non-overlay active pixels output sel_rgb with each channel shifted right by 1 (half brightness); overlay and blank behaviour are unchanged.
- Undefined: non-overlay pixels always output sel_rgb at full value.

Test Plan:
- Priority: COLOR_W = 4, layer_en = 8'b0000_0101, layer0 = 12'h00F, layer2 = 12'hF80, sync_ready = 1 -> 2 clocks later RGB = F,8,0. Next cycle layer_en = 0 -> BG_RGB = 0,0,0.
- Blank: sync_ready_sig = 0 with layer_en = 8'hFF -> RGB = 0,0,0 at latency 2. Raise sync_ready_sig -> top layer colour appears exactly 2 clocks later.
- Blink: ingame_sig 1->0, pic_over_data = 1, BLINK_FRAMES = 2, BLINK_TOGGLES = 2, 5 frame_start pulses spaced 10 clocks apart:
  - over_state = 1 the cycle after the fall.
  - Overlay F,0,0 is shown, then hidden after the 2nd pulse, then shown after the 4th.
  - over_state = 2 after the 4th pulse; the 5th pulse causes no change.
- Restart: in OVER_STEADY, raise ingame_sig in the same cycle as frame_start -> over_state = 0 next clock, counters 0, pic_over_data = 1 no longer produces the overlay.
- Reset mid-operation: pulse rst_n low in OVER_FLASH with active video -> outputs 0 and over_state 0 immediately (asynchronous); after release with ingame_sig = 1, normal mixing resumes at latency 2.
- DIM_BG_EN: with the macro defined, OVER_STEADY, pic_over_data = 0, top layer = 12'hF84 -> RGB = 7,4,2. With the macro undefined -> F,8,4.

Source files
------------

// File: rtl/tetris_pixel_mixer.sv
// tetris_pixel_mixer
//   Per-pixel colour compositor for the VGA Tetris display path. It merges
//   NUM_LAYERS prioritised colour layers into one RGB pixel, where the highest
//   index wins. It then applies a blinking-then-steady "GAME OVER" overlay.
//   Latency is 2 clocks, and the block accepts one pixel per clock.
//
//   Ports:
//     clk, rst_n       pixel clock, asynchronous active-low reset
//     sync_ready_sig   active video (low = blank, outputs forced to 0)
//     frame_start      one-cycle pulse per frame (drives blink timing)
//     ingame_sig       1 = game running, 0 = game over
//     layer_en         per-layer hit, [NUM_LAYERS]
//     layer_rgb        per-layer colour, layer i at [i*3*COLOR_W +: 3*COLOR_W]
//     pic_over_data    "GAME OVER" bitmap pixel
//     red_out/green_out/blue_out  composed colour, COLOR_W bits each
//     over_state       FSM state (0 PLAY, 1 OVER_FLASH, 2 OVER_STEADY)
//
//   Optional feature: define TETRIS_PIXEL_MIXER_DIM_BG_EN to halve the
//   brightness of non-overlay pixels while the game is over.
module tetris_pixel_mixer #(
   parameter int COLOR_W       = 4,
   parameter int NUM_LAYERS    = 8,
   parameter int BLINK_FRAMES  = 30,
   parameter int BLINK_TOGGLES = 6,
   parameter logic [3*COLOR_W-1:0] BG_RGB = '0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            sync_ready_sig,
   input  logic                            frame_start,
   input  logic                            ingame_sig,
   input  logic [NUM_LAYERS-1:0]           layer_en,
   input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
   input  logic                            pic_over_data,
   output logic [COLOR_W-1:0]              red_out,
   output logic [COLOR_W-1:0]              green_out,
   output logic [COLOR_W-1:0]              blue_out,
   output logic [1:0]                      over_state
);
   localparam int PW = 3*COLOR_W;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int TW = $clog2(BLINK_TOGGLES+1);

   typedef enum logic [1:0] {
      PLAY        = 2'd0,
      OVER_FLASH  = 2'd1,
      OVER_STEADY = 2'd2,
      ST_UNUSED   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   blink_cnt, blink_nxt;
   logic [TW-1:0]   tog_cnt, tog_nxt;
   logic            vis, vis_nxt;

   // ---------------- stage 1: priority select ----------------
   // Ascending scan, so the highest enabled index is the last one assigned.
   logic [PW-1:0]   sel_c, s1_rgb;
   logic            s1_hit, s1_over;
   logic [1:0]      vld_pipe;

   always_comb begin
      sel_c = BG_RGB;
      for (int i = 0; i < NUM_LAYERS; i++)
         if (layer_en[i]) sel_c = layer_rgb[i*PW +: PW];
   end

   assign vld_pipe[0] = sync_ready_sig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_rgb      <= '0;
         s1_hit      <= 1'b0;
         s1_over     <= 1'b0;
         vld_pipe[1] <= 1'b0;
      end else begin
         s1_rgb      <= sel_c;
         s1_hit      <= |layer_en;
         s1_over     <= pic_over_data;
         vld_pipe[1] <= vld_pipe[0];
      end
   end

   // ---------------- stage 2: overlay / blank ----------------
   // Live state and vis are used here. At a frame edge this can skew the
   // overlay by at most one pixel, which is acceptable.
   logic [PW-1:0] base_c, pix_c, pix_q;
   logic          overlay;

   assign overlay = (state != PLAY) && vis && s1_over;

   always_comb begin
      base_c = s1_hit ? s1_rgb : BG_RGB;
`ifdef TETRIS_PIXEL_MIXER_DIM_BG_EN
      if (state == OVER_FLASH || state == OVER_STEADY)
         base_c = {base_c[PW-1 -: COLOR_W] >> 1,
                   base_c[2*COLOR_W-1 -: COLOR_W] >> 1,
                   base_c[COLOR_W-1:0] >> 1};
`endif
      if (!vld_pipe[1])  pix_c = '0;
      else if (overlay)  pix_c = {{COLOR_W{1'b1}}, {2*COLOR_W{1'b0}}};
      else               pix_c = base_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pix_q <= '0;
      else        pix_q <= pix_c;
   end

   assign red_out    = pix_q[PW-1 -: COLOR_W];
   assign green_out  = pix_q[2*COLOR_W-1 -: COLOR_W];
   assign blue_out   = pix_q[COLOR_W-1:0];
   assign over_state = state;

   // ---------------- game-over FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PLAY;
         blink_cnt <= '0;
         tog_cnt   <= '0;
         vis       <= 1'b1;
      end else begin
         state     <= state_nxt;
         blink_cnt <= blink_nxt;
         tog_cnt   <= tog_nxt;
         vis       <= vis_nxt;
      end
   end

   // The counters are compared before they increment, so they never wrap.
   // A restart (ingame_sig) takes priority over a simultaneous frame_start.
   always_comb begin
      state_nxt = state;
      blink_nxt = blink_cnt;
      tog_nxt   = tog_cnt;
      vis_nxt   = vis;
      case (state)
         PLAY: begin
            if (!ingame_sig) begin
               state_nxt = OVER_FLASH;
               blink_nxt = '0;
               tog_nxt   = '0;
               vis_nxt   = 1'b1;
            end
         end
         OVER_FLASH: begin
            if (ingame_sig) begin
               state_nxt = PLAY;
               blink_nxt = '0;
               tog_nxt   = '0;
               vis_nxt   = 1'b1;
            end else if (frame_start) begin
               if (blink_cnt == BW'(BLINK_FRAMES-1)) begin
                  blink_nxt = '0;
                  vis_nxt   = ~vis;
                  tog_nxt   = tog_cnt + TW'(1);
                  if (tog_cnt == TW'(BLINK_TOGGLES-1)) begin
                     state_nxt = OVER_STEADY;
                     vis_nxt   = 1'b1;
                  end
               end else begin
                  blink_nxt = blink_cnt + BW'(1);
               end
            end
         end
         OVER_STEADY: begin
            vis_nxt = 1'b1;
            if (ingame_sig) begin
               state_nxt = PLAY;
               blink_nxt = '0;
               tog_nxt   = '0;
            end
         end
         default: begin
            state_nxt = PLAY;
            blink_nxt = '0;
            tog_nxt   = '0;
            vis_nxt   = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_tetris_pixel_mixer.sv
// Self-checking bench for tetris_pixel_mixer (BLINK_FRAMES=2, BLINK_TOGGLES=2).
// The reference model counts the frames elapsed since game over. From that
// count it derives the blink visibility and the steady state arithmetically.
module tb_tetris_pixel_mixer;
   localparam int BF = 2;
   localparam int BT = 2;
`ifdef TETRIS_PIXEL_MIXER_DIM_BG_EN
   localparam bit DIM = 1'b1;
`else
   localparam bit DIM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, sync_ready_sig, frame_start, ingame_sig, pic_over_data;
   logic [7:0]  layer_en;
   logic [95:0] layer_rgb;
   logic [3:0]  red_out, green_out, blue_out;
   logic [1:0]  over_state;
   logic [11:0] dut_rgb;

   int checks = 0;
   int fails  = 0;

   tetris_pixel_mixer #(.COLOR_W(4), .NUM_LAYERS(8), .BLINK_FRAMES(BF),
                        .BLINK_TOGGLES(BT), .BG_RGB(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .sync_ready_sig(sync_ready_sig),
      .frame_start(frame_start), .ingame_sig(ingame_sig),
      .layer_en(layer_en), .layer_rgb(layer_rgb),
      .pic_over_data(pic_over_data), .red_out(red_out),
      .green_out(green_out), .blue_out(blue_out), .over_state(over_state));

   always #5 clk = ~clk;
   assign dut_rgb = {red_out, green_out, blue_out};

   // ---------------- reference model ----------------
   logic [1:0]  m_state;
   int          m_f;
   logic        p_act, p_over;
   logic [11:0] p_sel, exp_rgb;

   function automatic logic [11:0] top_color(input logic [7:0] en, input logic [95:0] rgb);
      for (int i = 7; i >= 0; i--)
         if (en[i]) return rgb[i*12 +: 12];
      return 12'h000;
   endfunction

   function automatic logic [11:0] exp_pix(input logic act, input logic over,
                                           input logic [11:0] sel,
                                           input logic [1:0] st, input int f);
      bit shown;
      if (!act) return 12'h000;
      shown = (st == 2) || (st == 1 && ((f / BF) % 2) == 0);
      if (st != 0 && shown && over) return 12'hF00;
      if (DIM && st != 0) return {sel[11:8] >> 1, sel[7:4] >> 1, sel[3:0] >> 1};
      return sel;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 2'd0; m_f <= 0;
         p_act <= 1'b0; p_over <= 1'b0; p_sel <= 12'h000; exp_rgb <= 12'h000;
      end else begin
         exp_rgb <= exp_pix(p_act, p_over, p_sel, m_state, m_f);
         if (ingame_sig) begin
            m_state <= 2'd0; m_f <= 0;
         end else if (m_state == 2'd0) begin
            m_state <= 2'd1; m_f <= 0;
         end else if (m_state == 2'd1 && frame_start) begin
            m_f <= m_f + 1;
            if (m_f + 1 >= BF*BT) m_state <= 2'd2;
         end
         p_act  <= sync_ready_sig;
         p_over <= pic_over_data;
         p_sel  <= top_color(layer_en, layer_rgb);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0; sync_ready_sig = 1'b1; frame_start = 1'b0; ingame_sig = 1'b1;
      layer_en = 8'hFF; layer_rgb = {$urandom, $urandom, $urandom}; pic_over_data = 1'b1;
      cyc(3);
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h want 000", dut_rgb); end
      checks++;
      if (over_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", over_state); end
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_priority;
      ingame_sig = 1'b1; sync_ready_sig = 1'b1; pic_over_data = 1'b0;
      layer_rgb = {$urandom, $urandom, $urandom};
      layer_rgb[0 +: 12] = 12'h00F;
      layer_rgb[24 +: 12] = 12'hF80;
      layer_en = 8'b0000_0101;
      cyc();
      layer_en = 8'h00;
      cyc();
      checks++;
      if (dut_rgb !== 12'hF80) begin fails++; $display("FAIL priority: got %h want F80", dut_rgb); end
      cyc();
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL priority_bg: got %h want 000", dut_rgb); end
   endtask

   task automatic test_blank;
      sync_ready_sig = 1'b0; layer_en = 8'hFF; layer_rgb[84 +: 12] = 12'h3C5;
      cyc(2);
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL blank: got %h want 000", dut_rgb); end
      sync_ready_sig = 1'b1;
      cyc();
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL blank_lat1: got %h want 000", dut_rgb); end
      cyc();
      checks++;
      if (dut_rgb !== 12'h3C5) begin fails++; $display("FAIL blank_lat2: got %h want 3C5", dut_rgb); end
   endtask

   task automatic test_random_mix;
      ingame_sig = 1'b1; frame_start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         sync_ready_sig = ($urandom % 5) != 0;
         layer_en = 8'($urandom) & 8'($urandom);
         layer_rgb = {$urandom, $urandom, $urandom};
         pic_over_data = 1'($urandom);
         cyc();
         checks++;
         if (dut_rgb !== exp_rgb) begin
            fails++; $display("FAIL mix cyc %0d: got %h want %h", i, dut_rgb, exp_rgb);
         end
      end
   endtask

   task automatic test_blink;
      logic [11:0] hidden;
      hidden = DIM ? 12'h052 : 12'h0A5;
      ingame_sig = 1'b1; sync_ready_sig = 1'b1; pic_over_data = 1'b1; frame_start = 1'b0;
      layer_en = 8'h01; layer_rgb[0 +: 12] = 12'h0A5;
      cyc(3);
      ingame_sig = 1'b0;
      cyc();
      checks++;
      if (over_state !== 2'd1) begin fails++; $display("FAIL blink_enter: got %0d want 1", over_state); end
      cyc(2);
      checks++;
      if (dut_rgb !== 12'hF00) begin fails++; $display("FAIL blink_first: got %h want F00", dut_rgb); end
      for (int p = 1; p <= 5; p++) begin
         logic [11:0] want_rgb;
         logic [1:0]  want_st;
         frame_start = 1'b1;
         cyc();
         frame_start = 1'b0;
         for (int k = 0; k < 9; k++) begin
            cyc();
            checks++;
            if (dut_rgb !== exp_rgb) begin
               fails++; $display("FAIL blink_model p%0d k%0d: got %h want %h", p, k, dut_rgb, exp_rgb);
            end
         end
         want_rgb = (p == 2 || p == 3) ? hidden : 12'hF00;
         want_st  = (p >= 4) ? 2'd2 : 2'd1;
         checks++;
         if (dut_rgb !== want_rgb) begin
            fails++; $display("FAIL blink_rgb p%0d: got %h want %h", p, dut_rgb, want_rgb);
         end
         checks++;
         if (over_state !== want_st) begin
            fails++; $display("FAIL blink_state p%0d: got %0d want %0d", p, over_state, want_st);
         end
      end
   endtask

   task automatic test_restart;
      ingame_sig = 1'b1; frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      checks++;
      if (over_state !== 2'd0) begin fails++; $display("FAIL restart_state: got %0d want 0", over_state); end
      cyc();
      checks++;
      if (dut_rgb !== 12'h0A5) begin fails++; $display("FAIL restart_rgb: got %h want 0A5", dut_rgb); end
      // The counters must have restarted: one frame later the overlay is still
      // shown, and after the second frame it is hidden.
      ingame_sig = 1'b0;
      cyc(3);
      frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc(3);
      checks++;
      if (dut_rgb !== 12'hF00) begin fails++; $display("FAIL restart_cnt1: got %h want F00", dut_rgb); end
      frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc(3);
      checks++;
      if (dut_rgb !== exp_rgb || dut_rgb === 12'hF00) begin
         fails++; $display("FAIL restart_cnt2: got %h want %h", dut_rgb, exp_rgb);
      end
   endtask

   task automatic test_reset_mid;
      // The block is in OVER_FLASH here, with active video.
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL rstmid_rgb: got %h want 000", dut_rgb); end
      checks++;
      if (over_state !== 2'd0) begin fails++; $display("FAIL rstmid_state: got %0d want 0", over_state); end
      cyc();
      ingame_sig = 1'b1; pic_over_data = 1'b1; layer_en = 8'h01; layer_rgb[0 +: 12] = 12'h0A5;
      rst_n = 1'b1;
      cyc();
      checks++;
      if (dut_rgb !== 12'h000) begin fails++; $display("FAIL rstmid_lat1: got %h want 000", dut_rgb); end
      cyc();
      checks++;
      if (dut_rgb !== 12'h0A5) begin fails++; $display("FAIL rstmid_lat2: got %h want 0A5", dut_rgb); end
   endtask

   task automatic test_dim;
      logic [11:0] want;
      want = DIM ? 12'h742 : 12'hF84;
      ingame_sig = 1'b0; pic_over_data = 1'b0; layer_en = 8'h01; layer_rgb[0 +: 12] = 12'hF84;
      cyc(2);
      repeat (4) begin frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc(2); end
      checks++;
      if (over_state !== 2'd2) begin fails++; $display("FAIL dim_state: got %0d want 2", over_state); end
      checks++;
      if (dut_rgb !== want) begin fails++; $display("FAIL dim_rgb: got %h want %h", dut_rgb, want); end
   endtask

   task automatic test_fsm_random;
      for (int i = 0; i < 2000; i++) begin
         ingame_sig = ($urandom % 40) == 0;
         frame_start = ($urandom % 4) == 0;
         sync_ready_sig = ($urandom % 6) != 0;
         pic_over_data = 1'($urandom);
         layer_en = 8'($urandom);
         layer_rgb = {$urandom, $urandom, $urandom};
         cyc();
         checks++;
         if (dut_rgb !== exp_rgb || over_state !== m_state) begin
            fails++;
            $display("FAIL fsm cyc %0d: got %h/%0d want %h/%0d", i, dut_rgb, over_state, exp_rgb, m_state);
         end
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_blank();
      test_random_mix();
      test_blink();
      test_restart();
      test_reset_mid();
      test_dim();
      test_fsm_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
